// File: rtl/time_display_scan.sv
// Four-digit seven-segment scanner for the packed-BCD 24-hour time bus.
// One snapshot per scan frame, blinking colon, leading-zero blanking and bad-time masking.
module time_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int BLINK_FRAMES = 125,
  parameter bit ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic       colon,
  output logic [3:0] digit_en,
  output logic       frame_start,
  output logic       bad_time
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_ON   = PW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRM_MAX  = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_POL  = {7{ACTIVE_LOW}};
  localparam logic [3:0]    EN_POL   = {4{ACTIVE_LOW}};
  localparam logic [6:0]    SEG_DASH = 7'b1000000;

  logic [PW-1:0] prescaler, prescaler_n;
  logic [1:0]    idx, idx_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic          colon_phase, colon_phase_n;
  logic [15:0]   snapshot, snapshot_n;
  logic          first;
  logic          bad_n;
  logic          load;
  logic          slot_on;
  logic [3:0]    nibble;
  logic [6:0]    seg_n;
  logic          colon_n;
  logic [3:0]    en_n;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic time_valid(input logic [15:0] t);
    logic hour_ok;
    hour_ok = (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) &&
              ((t[15:12] != 4'd2) || (t[11:8] <= 4'd3));
    return hour_ok && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  // Next-state and next-output logic; outputs are computed from the state
  // being loaded so that they change on the same edge as the state.
  always_comb begin
    prescaler_n   = prescaler;
    idx_n         = idx;
    frame_cnt_n   = frame_cnt;
    colon_phase_n = colon_phase;
    snapshot_n    = snapshot;
    bad_n         = bad_time;
    load          = 1'b0;

    if (first) begin
      load        = 1'b1;
      prescaler_n = '0;
      idx_n       = 2'd3;
    end else if (prescaler == PRE_MAX) begin
      prescaler_n = '0;
      idx_n       = idx - 2'd1;
      if (idx == 2'd0) begin
        load = 1'b1;
        if (frame_cnt == FRM_MAX) begin
          frame_cnt_n   = '0;
          colon_phase_n = ~colon_phase;
        end else begin
          frame_cnt_n = frame_cnt + 1'b1;
        end
      end
    end else begin
      prescaler_n = prescaler + 1'b1;
    end

    if (load) begin
      snapshot_n = {hour, minute};
      bad_n      = ~time_valid({hour, minute});
    end

    case (idx_n)
      2'd3:    nibble = snapshot_n[15:12];
      2'd2:    nibble = snapshot_n[11:8];
      2'd1:    nibble = snapshot_n[7:4];
      default: nibble = snapshot_n[3:0];
    endcase

    slot_on = (prescaler_n >= PRE_ON);
    en_n    = slot_on ? (4'b0001 << idx_n) : 4'b0000;

    if (bad_n)
      seg_n = SEG_DASH;
    else if (blank_lead && (idx_n == 2'd3) && (snapshot_n[15:12] == 4'd0))
      seg_n = 7'b0000000;
    else
      seg_n = decode(nibble);

    colon_n = (idx_n == 2'd2) && slot_on && colon_phase_n && !bad_n;
  end

  // Scan state and output registers; polarity is applied only here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      idx         <= 2'd3;
      frame_cnt   <= '0;
      colon_phase <= 1'b0;
      snapshot    <= 16'h0000;
      first       <= 1'b1;
      seg         <= SEG_POL;
      colon       <= ACTIVE_LOW;
      digit_en    <= EN_POL;
      frame_start <= 1'b0;
      bad_time    <= 1'b0;
    end else begin
      prescaler   <= prescaler_n;
      idx         <= idx_n;
      frame_cnt   <= frame_cnt_n;
      colon_phase <= colon_phase_n;
      snapshot    <= snapshot_n;
      first       <= 1'b0;
      seg         <= seg_n ^ SEG_POL;
      colon       <= colon_n ^ ACTIVE_LOW;
      digit_en    <= en_n ^ EN_POL;
      frame_start <= load;
      bad_time    <= bad_n;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan: directed test-plan steps plus random time values,
// checked every cycle against a frame/slot arithmetic model of the display.
module tb_time_display_scan;

  localparam int SD    = 4;
  localparam int BL    = 1;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hour;
  logic [7:0] minute;
  logic       blank_lead;
  logic [6:0] seg;
  logic       colon;
  logic [3:0] digit_en;
  logic       frame_start;
  logic       bad_time;

  int checks = 0;
  int errors = 0;

  // model state: edges since reset release (-1 = waiting for first edge)
  int          t = -1;
  logic [15:0] snap = 16'h0000;
  logic        snap_bad = 1'b0;
  logic [6:0]  seg_table [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  time_display_scan #(
    .SCAN_DIV(SD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .hour(hour), .minute(minute),
    .blank_lead(blank_lead), .seg(seg), .colon(colon), .digit_en(digit_en),
    .frame_start(frame_start), .bad_time(bad_time)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit time_ok(input logic [15:0] v);
    int ht, hu, mt, mu;
    ht = int'(v[15:12]);
    hu = int'(v[11:8]);
    mt = int'(v[7:4]);
    mu = int'(v[3:0]);
    return (mu <= 9) && (mt <= 5) && (hu <= 9) && (ht * 10 + hu <= 23);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens, units;
    tens  = 4'(v / 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic bl);
    hour       = h;
    minute     = m;
    blank_lead = bl;
  endtask

  task automatic checkOutput();
    logic [6:0] e_seg;
    logic [3:0] e_en;
    logic       e_colon, e_fs, e_bad, on, phase;
    int         pre, idx, frame, nib;
    if (t < 0) begin
      e_seg = 7'h7F; e_en = 4'hF; e_colon = 1'b1; e_fs = 1'b0; e_bad = 1'b0;
    end else begin
      pre   = t % SD;
      idx   = 3 - (t / SD) % 4;
      frame = t / FRAME;
      phase = ((frame / BF) % 2) == 1;
      on    = pre >= BL;
      nib   = int'((snap >> (4 * idx)) & 16'hF);
      if (snap_bad)
        e_seg = 7'b1000000;
      else if (blank_lead && idx == 3 && snap[15:12] == 4'd0)
        e_seg = 7'b0000000;
      else
        e_seg = (nib <= 9) ? seg_table[nib] : 7'b0000000;
      e_en    = on ? 4'(1 << idx) : 4'b0000;
      e_colon = (idx == 2) && on && phase && !snap_bad;
      e_fs    = (t % FRAME) == 0;
      e_bad   = snap_bad;
      e_seg   = ~e_seg;
      e_en    = ~e_en;
      e_colon = ~e_colon;
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++;
      $error("[TB] FAIL seg t=%0d observed %b expected %b", t, seg, e_seg);
    end
    checks++;
    assert (digit_en === e_en) else begin
      errors++;
      $error("[TB] FAIL digit_en t=%0d observed %b expected %b", t, digit_en, e_en);
    end
    checks++;
    assert (colon === e_colon) else begin
      errors++;
      $error("[TB] FAIL colon t=%0d observed %b expected %b", t, colon, e_colon);
    end
    checks++;
    assert (frame_start === e_fs) else begin
      errors++;
      $error("[TB] FAIL frame_start t=%0d observed %b expected %b", t, frame_start, e_fs);
    end
    checks++;
    assert (bad_time === e_bad) else begin
      errors++;
      $error("[TB] FAIL bad_time t=%0d observed %b expected %b", t, bad_time, e_bad);
    end
  endtask

  // one clock: advance the model with the inputs seen at the rising edge,
  // then compare on the falling edge
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      t++;
      if (t % FRAME == 0) begin
        snap     = {hour, minute};
        snap_bad = !time_ok({hour, minute});
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int pos);
    for (int i = 0; i <= FRAME; i++) begin
      if (t >= 0 && (t % FRAME) == pos) break;
      tick();
    end
  endtask

  initial begin
    int h, m, n;
    reset = 1'b1;
    applyStimulus(8'h12, 8'h34, 1'b0);
    run(2);
    reset = 1'b0;
    $display("[TB] basic scan of 12:34 over four frames");
    run(4 * FRAME);

    $display("[TB] minute change mid-frame");
    run_until(5);
    applyStimulus(8'h12, 8'h35, 1'b0);
    run(2 * FRAME);

    $display("[TB] invalid hour then restore");
    applyStimulus(8'h24, 8'h35, 1'b0);
    run(2 * FRAME);
    applyStimulus(8'h23, 8'h35, 1'b0);
    run(2 * FRAME);

    $display("[TB] leading-zero blanking");
    applyStimulus(8'h07, 8'h35, 1'b1);
    run(2 * FRAME);
    applyStimulus(8'h07, 8'h35, 1'b0);
    run(FRAME + 4);

    $display("[TB] asynchronous reset during idx=1 slot");
    run_until(9);
    #2;
    reset = 1'b1;
    t = -1;
    #1;
    checkOutput();
    run(2);
    reset = 1'b0;
    applyStimulus(8'h21, 8'h58, 1'b0);
    run(2 * FRAME);

    $display("[TB] random time values");
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        hour   = 8'($urandom);
        minute = 8'($urandom);
      end else begin
        h = int'($urandom_range(0, 23));
        m = int'($urandom_range(0, 59));
        hour   = to_bcd(h);
        minute = to_bcd(m);
      end
      blank_lead = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 24));
      run(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
